// File: rtl/mod_exp_ctrl.sv
// mod_exp_ctrl: left-to-right square-and-multiply sequencer for base^exponent mod N.
// Every modular product is delegated to an external Montgomery multiplier.
// Operands enter the Montgomery domain through r2_mod and leave it with a final MM(x, 1).
module mod_exp_ctrl #(
  parameter int MAX_EXP = 32
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        sig_start,
  input  logic [7:0]  len,
  input  logic [31:0] base,
  input  logic [31:0] exponent,
  input  logic [5:0]  exp_bits,
  input  logic [31:0] modulus,
  input  logic [31:0] r2_mod,
  output logic        mm_start,
  output logic [7:0]  mm_len,
  output logic [31:0] mm_a,
  output logic [31:0] mm_b,
  output logic [31:0] mm_mod,
  input  logic        mm_end,
  input  logic [31:0] mm_out,
  output logic        busy,
  output logic        module_end,
  output logic [31:0] me_out
);

  localparam logic [5:0]  MAX_BITS = 6'(MAX_EXP);
  localparam logic [31:0] ONE      = 32'd1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TO_M,
    S_TO_X,
    S_SQUARE,
    S_MULT,
    S_FROM,
    S_DONE
  } state_t;

  state_t      state, state_nxt;

  // Operation context, latched when a start is accepted.
  logic [31:0] base_q;
  logic [31:0] exp_q;
  logic [31:0] r2_q;
  logic [5:0]  ebits_q;
  logic [4:0]  idx;

  // Montgomery-domain working values.
  logic [31:0] m_bar;
  logic [31:0] x_bar;

  // ph_wait: 0 = ISSUE phase, 1 = WAIT phase of the current multiply.
  // skip: set for the first WAIT edge, where the multiplier may still show
  // the module_end of the previous product.
  logic        ph_wait;
  logic        skip;

  logic        accept;
  logic        issue;
  logic        capture;
  logic        idx_dec;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [5:0]  ebits_cl;

  // Exponent bit counts beyond the supported width are treated as the maximum.
  function automatic logic [5:0] clamp_bits(input logic [5:0] b);
    return (b > MAX_BITS) ? MAX_BITS : b;
  endfunction

  assign ebits_cl = clamp_bits(exp_bits);

  // Next-state, handshake strobes and operand selection for the current multiply.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    issue     = 1'b0;
    capture   = 1'b0;
    idx_dec   = 1'b0;
    op_a      = '0;
    op_b      = '0;

    case (state)
      S_IDLE: begin
        if (sig_start && !busy) begin
          accept    = 1'b1;
          state_nxt = S_TO_M;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        if (!ph_wait) begin
          issue = 1'b1;
        end else if (!skip && mm_end) begin
          capture = 1'b1;
        end
      end
    endcase

    case (state)
      S_TO_M: begin
        op_a = base_q;
        op_b = r2_q;
      end
      S_TO_X: begin
        op_a = ONE;
        op_b = r2_q;
      end
      S_SQUARE: begin
        op_a = x_bar;
        op_b = x_bar;
      end
      S_MULT: begin
        op_a = m_bar;
        op_b = x_bar;
      end
      S_FROM: begin
        op_a = x_bar;
        op_b = ONE;
      end
      default: begin
        op_a = '0;
        op_b = '0;
      end
    endcase

    if (capture) begin
      case (state)
        S_TO_M: state_nxt = S_TO_X;
        S_TO_X: state_nxt = (ebits_q != 6'd0) ? S_SQUARE : S_FROM;
        S_SQUARE: begin
          if (exp_q[idx]) begin
            state_nxt = S_MULT;
          end else if (idx == 5'd0) begin
            state_nxt = S_FROM;
          end else begin
            state_nxt = S_SQUARE;
            idx_dec   = 1'b1;
          end
        end
        S_MULT: begin
          if (idx == 5'd0) begin
            state_nxt = S_FROM;
          end else begin
            state_nxt = S_SQUARE;
            idx_dec   = 1'b1;
          end
        end
        S_FROM: state_nxt = S_DONE;
        default: state_nxt = state;
      endcase
    end
  end

  // State register, multiplier handshake, status flags and result register.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= S_IDLE;
      ph_wait    <= 1'b0;
      skip       <= 1'b0;
      idx        <= '0;
      busy       <= 1'b0;
      module_end <= 1'b0;
      mm_start   <= 1'b0;
      mm_a       <= '0;
      mm_b       <= '0;
      mm_len     <= '0;
      mm_mod     <= '0;
      me_out     <= '0;
    end else begin
      state      <= state_nxt;
      mm_start   <= issue;
      skip       <= issue;
      module_end <= (state == S_DONE);

      if (accept) begin
        busy    <= 1'b1;
        ph_wait <= 1'b0;
        mm_len  <= len;
        mm_mod  <= modulus;
        idx     <= 5'(ebits_cl - 6'd1);
      end else if (state == S_IDLE) begin
        busy <= 1'b0;
      end

      if (issue) begin
        ph_wait <= 1'b1;
        mm_a    <= op_a;
        mm_b    <= op_b;
      end

      if (capture) begin
        ph_wait <= 1'b0;
        if (state == S_FROM) begin
          me_out <= mm_out;
        end
      end

      if (idx_dec) begin
        idx <= idx - 5'd1;
      end
    end
  end

  // Operation context and Montgomery working registers; every value is
  // rewritten before use in each run, so no reset is needed here.
  always_ff @(posedge clk) begin
    if (accept) begin
      base_q  <= base;
      exp_q   <= exponent;
      r2_q    <= r2_mod;
      ebits_q <= ebits_cl;
    end
    if (capture) begin
      case (state)
        S_TO_M:                  m_bar <= mm_out;
        S_TO_X, S_SQUARE, S_MULT: x_bar <= mm_out;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mod_exp_ctrl.sv
// tb_mod_exp_ctrl: directed bench for mod_exp_ctrl with a behavioural Montgomery
// multiplier that keeps module_end high (stale) until its next start.
module tb_mod_exp_ctrl;

  logic        clk = 1'b0;
  logic        rstn;
  logic        sig_start;
  logic [7:0]  len_i;
  logic [31:0] base_i;
  logic [31:0] exp_i;
  logic [5:0]  ebits_i;
  logic [31:0] mod_i;
  logic [31:0] r2_i;
  logic        mm_start;
  logic [7:0]  mm_len;
  logic [31:0] mm_a;
  logic [31:0] mm_b;
  logic [31:0] mm_mod;
  logic        mdl_end = 1'b0;
  logic [31:0] mdl_out = 32'd0;
  logic        busy;
  logic        module_end;
  logic [31:0] me_out;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  mod_exp_ctrl #(.MAX_EXP(32)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .sig_start  (sig_start),
    .len        (len_i),
    .base       (base_i),
    .exponent   (exp_i),
    .exp_bits   (ebits_i),
    .modulus    (mod_i),
    .r2_mod     (r2_i),
    .mm_start   (mm_start),
    .mm_len     (mm_len),
    .mm_a       (mm_a),
    .mm_b       (mm_b),
    .mm_mod     (mm_mod),
    .mm_end     (mdl_end),
    .mm_out     (mdl_out),
    .busy       (busy),
    .module_end (module_end),
    .me_out     (me_out)
  );

  // Montgomery product a*b*2^-l mod n by bitwise halving.
  function automatic logic [31:0] mont(input logic [31:0] a, input logic [31:0] b,
                                       input logic [31:0] n, input logic [7:0] l);
    logic [63:0] t;
    t = (64'(a) * 64'(b)) % 64'(n);
    for (int k = 0; k < int'(l); k++) begin
      if (t[0]) t = t + 64'(n);
      t = t >> 1;
    end
    return t[31:0];
  endfunction

  // Behavioural multiplier: latency L (start edge to sampled end edge), 0 = random 2..20.
  int          lat_fix = 3;
  int          mdl_l;
  int          mdl_cnt = 0;
  bit          mdl_pend = 1'b0;
  logic [31:0] mdl_res = 32'd0;
  logic [31:0] mdl_r;

  always @(posedge clk) begin
    if (mm_start) begin
      mdl_l = (lat_fix != 0) ? lat_fix : int'($urandom_range(20, 2));
      mdl_r = mont(mm_a, mm_b, mm_mod, mm_len);
      if (mdl_l == 2) begin
        mdl_end  <= 1'b1;
        mdl_out  <= mdl_r;
        mdl_pend <= 1'b0;
      end else begin
        mdl_end  <= 1'b0;
        mdl_res  <= mdl_r;
        mdl_cnt  <= mdl_l - 2;
        mdl_pend <= 1'b1;
      end
    end else if (mdl_pend) begin
      if (mdl_cnt == 1) begin
        mdl_end  <= 1'b1;
        mdl_out  <= mdl_res;
        mdl_pend <= 1'b0;
      end
      mdl_cnt <= mdl_cnt - 1;
    end
  end

  // Pulse counters and operand-stability watch during multiplier WAIT.
  int          n_start = 0;
  int          n_end   = 0;
  int          stab_viol = 0;
  bit          stab_en = 1'b0;
  logic [31:0] sa = 32'd0;
  logic [31:0] sb = 32'd0;

  always @(negedge clk) begin
    if (mm_start) begin
      n_start++;
      sa = mm_a;
      sb = mm_b;
    end else if (stab_en && mdl_pend && (mm_a != sa || mm_b != sb)) begin
      stab_viol++;
    end
    if (module_end) n_end++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // One full exponentiation mod 13 (len=4, r2=9); optional extra starts mid-run and in DONE.
  task automatic run_op(input string tag, input logic [31:0] b, input logic [31:0] e,
                        input logic [5:0] eb, input logic [31:0] exp_res,
                        input int exp_starts, input bit poke);
    int s0, e0, cyc;
    bit done;
    @(negedge clk);
    len_i = 8'd4; base_i = b; exp_i = e; ebits_i = eb; mod_i = 32'd13; r2_i = 32'd9;
    sig_start = 1'b1;
    s0 = n_start;
    e0 = n_end;
    @(negedge clk);
    sig_start = 1'b0;
    check({tag, " busy"}, 32'(busy), 32'd1);
    done = 1'b0;
    cyc  = 0;
    while (!done && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (module_end) begin
        done = 1'b1;
      end else if (poke && cyc == 15) begin
        sig_start = 1'b1;
        base_i    = 32'd3;
      end else begin
        sig_start = 1'b0;
      end
    end
    if (!done) check({tag, " timeout"}, 32'd0, 32'd1);
    check({tag, " me_out"}, me_out, exp_res);
    if (poke) begin
      sig_start = 1'b1;
      @(negedge clk);
      sig_start = 1'b0;
    end
    repeat (8) @(negedge clk);
    check({tag, " starts"}, 32'(n_start - s0), 32'(exp_starts));
    check({tag, " ends"}, 32'(n_end - e0), 32'd1);
    check({tag, " idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int s0, cyc;
    // Reset with random inputs and start held high.
    rstn = 1'b0;
    sig_start = 1'b1;
    len_i = 8'($urandom); base_i = $urandom; exp_i = $urandom; ebits_i = 6'($urandom);
    mod_i = $urandom; r2_i = $urandom;
    repeat (3) @(negedge clk);
    check("rst mm_start", 32'(mm_start), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst module_end", 32'(module_end), 32'd0);
    check("rst mm_a", mm_a, 32'd0);
    check("rst mm_b", mm_b, 32'd0);
    check("rst mm_len", 32'(mm_len), 32'd0);
    check("rst mm_mod", mm_mod, 32'd0);
    check("rst me_out", me_out, 32'd0);
    check("rst no starts", 32'(n_start), 32'd0);
    sig_start = 1'b0;
    rstn = 1'b1;
    @(negedge clk);

    lat_fix = 3;
    run_op("7^3", 32'd7, 32'd3, 6'd2, 32'd5, 7, 1'b0);

    lat_fix = 4;
    stab_en = 1'b1;
    run_op("2^10", 32'd2, 32'd10, 6'd4, 32'd10, 9, 1'b0);
    stab_en = 1'b0;
    check("2^10 operands stable", 32'(stab_viol), 32'd0);

    lat_fix = 2;
    run_op("ebits0", 32'd7, 32'd0, 6'd0, 32'd1, 3, 1'b0);
    run_op("base0", 32'd0, 32'd5, 6'd3, 32'd0, 8, 1'b0);

    lat_fix = 0;
    run_op("rand 2^11", 32'd2, 32'd11, 6'd4, 32'd7, 10, 1'b1);
    run_op("clamp", 32'd6, 32'd1, 6'd40, 32'd6, 36, 1'b0);

    // Abort in the WAIT of the 4th multiply, then a clean run.
    lat_fix = 6;
    @(negedge clk);
    len_i = 8'd4; base_i = 32'd2; exp_i = 32'd10; ebits_i = 6'd4; mod_i = 32'd13; r2_i = 32'd9;
    sig_start = 1'b1;
    s0 = n_start;
    @(negedge clk);
    sig_start = 1'b0;
    cyc = 0;
    while ((n_start - s0) < 4 && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 500) check("abort reach 4th", 32'd0, 32'd1);
    repeat (2) @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    check("abort busy", 32'(busy), 32'd0);
    check("abort me_out", me_out, 32'd0);
    check("abort mm_a", mm_a, 32'd0);
    s0 = n_start;
    repeat (20) @(negedge clk);
    check("abort no issue", 32'(n_start - s0), 32'd0);
    check("abort me_out held", me_out, 32'd0);
    run_op("after abort", 32'd7, 32'd3, 6'd2, 32'd5, 7, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
